// File: rtl/spm_window_stream_if.sv
// Host memory port and kernel access port of the scratchpad window.
// master = the window block, slave = the host/kernel side that talks to it.
interface spm_window_stream_if #(
    parameter int DATA_WID = 32
);
    logic                hrd_en;
    logic [63:0]         hrd_addr;
    logic                hrd_ready;
    logic [DATA_WID-1:0] hrd_data;

    logic                hwr_en;
    logic [63:0]         hwr_addr;
    logic [DATA_WID-1:0] hwr_data;
    logic                hwr_ready;

    logic                k_rd_en;
    logic [63:0]         k_rd_addr;
    logic [DATA_WID-1:0] k_rd_data;
    logic                k_rd_ready;

    logic                k_wr_en;
    logic [63:0]         k_wr_addr;
    logic [DATA_WID-1:0] k_wr_data;
    logic                k_wr_ready;

    modport master (
        output hrd_en, hrd_addr, input hrd_ready, hrd_data,
        output hwr_en, hwr_addr, hwr_data, input hwr_ready,
        input  k_rd_en, k_rd_addr, output k_rd_data, k_rd_ready,
        input  k_wr_en, k_wr_addr, k_wr_data, output k_wr_ready
    );

    modport slave (
        input  hrd_en, hrd_addr, output hrd_ready, hrd_data,
        input  hwr_en, hwr_addr, hwr_data, output hwr_ready,
        output k_rd_en, k_rd_addr, input k_rd_data, k_rd_ready,
        output k_wr_en, k_wr_addr, k_wr_data, input k_wr_ready
    );
endinterface

// File: rtl/spm_window_stream.sv
// Scratchpad window between a streaming kernel and host memory: preload, fixed-latency
// serve, reload on out-of-window access, and dirty-range-only write-back.
module spm_window_stream #(
    parameter int DATA_WID  = 32,
    parameter int ADDR_WID  = 13,
    parameter int SPM_LAT   = 5,
    parameter int RELOAD_EN = 1
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic [63:0] read_base,
    input  logic [63:0] num_words,
    output logic        k_reset,
    input  logic        k_done,
    output logic        done,
    spm_window_stream_if.master bus
);
    localparam int WB    = DATA_WID / 8;
    localparam int DEPTH = 2 ** ADDR_WID;
    localparam logic [63:0] WB64  = 64'(WB);
    localparam logic [63:0] WIN64 = 64'(DEPTH * WB);
    localparam int CNT_W = (SPM_LAT < 1) ? 1 : $clog2(SPM_LAT + 1);
    localparam logic [CNT_W-1:0]  LAT_CNT  = CNT_W'(SPM_LAT);
    localparam logic [ADDR_WID:0] LO_EMPTY = (ADDR_WID + 1)'(DEPTH);

    localparam logic [2:0] S_IDLE     = 3'd0;
    localparam logic [2:0] S_FILL     = 3'd1;
    localparam logic [2:0] S_RUN      = 3'd2;
    localparam logic [2:0] S_SPM_WAIT = 3'd3;
    localparam logic [2:0] S_HOST_RD  = 3'd4;
    localparam logic [2:0] S_HOST_WR  = 3'd5;
    localparam logic [2:0] S_FLUSH    = 3'd6;
    localparam logic [2:0] S_DONE     = 3'd7;

    logic [2:0]          state_reg;
    logic [63:0]         base_reg, end_reg, head_reg, reload_head_reg, fill_addr_reg, kaddr_reg;
    logic [ADDR_WID-1:0] fill_idx_reg, idx_reg, fl_idx_reg;
    logic [ADDR_WID:0]   lo_reg, hi_reg;
    logic [CNT_W-1:0]    cnt_reg;
    logic                op_wr_reg, to_done_reg, fl_valid_reg, k_reset_reg, done_reg;
    logic [DATA_WID-1:0] kwdata_reg, rdata_reg;
    logic [DATA_WID-1:0] mem [DEPTH];

    logic [63:0]         win_lim, win_end, req_addr, new_head;
    logic                req_any, req_wr, in_win, reload_hit;
    logic [ADDR_WID-1:0] req_idx, ram_raddr, ram_waddr;
    logic [DATA_WID-1:0] ram_wdata;
    logic                ram_we, fill_req, fill_beat, fill_last, spm_done;
    logic                spm_rd_hit, host_rd_hit, dirty_empty, flush_last;

    // A window never reaches past the end of the data set.
    assign win_lim = head_reg + WIN64;
    assign win_end = (win_lim < end_reg) ? win_lim : end_reg;

    assign req_wr   = !bus.k_rd_en && bus.k_wr_en;
    assign req_any  = bus.k_rd_en || bus.k_wr_en;
    assign req_addr = bus.k_rd_en ? bus.k_rd_addr : bus.k_wr_addr;
    assign in_win   = (req_addr >= head_reg) && (req_addr < win_end);
    assign req_idx  = ADDR_WID'((req_addr - head_reg) / WB64);
    assign reload_hit = (RELOAD_EN != 0) && (req_addr >= base_reg) && (req_addr < end_reg);
    assign new_head = req_addr - ((req_addr - base_reg) % WIN64);

    assign fill_req    = (state_reg == S_FILL) && (fill_addr_reg < win_end);
    assign fill_beat   = fill_req && bus.hrd_ready;
    assign fill_last   = (fill_addr_reg + WB64) >= win_end;
    assign spm_done    = (state_reg == S_SPM_WAIT) && (cnt_reg == '0);
    assign spm_rd_hit  = spm_done && !op_wr_reg;
    assign host_rd_hit = (state_reg == S_HOST_RD) && bus.hrd_ready;
    assign dirty_empty = lo_reg > hi_reg;
    assign flush_last  = fl_valid_reg && bus.hwr_ready && ({1'b0, fl_idx_reg} == hi_reg);

    assign bus.hrd_en   = fill_req || (state_reg == S_HOST_RD);
    assign bus.hrd_addr = (state_reg == S_FILL)    ? fill_addr_reg :
                          (state_reg == S_HOST_RD) ? kaddr_reg : '0;
    assign bus.hwr_en   = ((state_reg == S_FLUSH) && fl_valid_reg) || (state_reg == S_HOST_WR);
    assign bus.hwr_addr = ((state_reg == S_FLUSH) && fl_valid_reg) ? head_reg + 64'(fl_idx_reg) * WB64 :
                          (state_reg == S_HOST_WR) ? kaddr_reg : '0;
    assign bus.hwr_data = ((state_reg == S_FLUSH) && fl_valid_reg) ? rdata_reg :
                          (state_reg == S_HOST_WR) ? kwdata_reg : '0;

    assign bus.k_rd_ready = spm_rd_hit || host_rd_hit;
    assign bus.k_rd_data  = spm_rd_hit ? rdata_reg : (host_rd_hit ? bus.hrd_data : '0);
    assign bus.k_wr_ready = (spm_done && op_wr_reg) || ((state_reg == S_HOST_WR) && bus.hwr_ready);
    assign k_reset = k_reset_reg;
    assign done    = done_reg;

    // The RUN-cycle read address lets the data be ready even when SPM_LAT is zero.
    assign ram_raddr = (state_reg == S_RUN)   ? req_idx :
                       (state_reg == S_FLUSH) ? fl_idx_reg : idx_reg;
    assign ram_we    = fill_beat || (spm_done && op_wr_reg);
    assign ram_waddr = (state_reg == S_FILL) ? fill_idx_reg : idx_reg;
    assign ram_wdata = (state_reg == S_FILL) ? bus.hrd_data : kwdata_reg;

    always_ff @(posedge clk) begin
        if (ram_we) begin
            mem[ram_waddr] <= ram_wdata;
        end
        rdata_reg <= mem[ram_raddr];
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_reg       <= S_IDLE;
            base_reg        <= '0;
            end_reg         <= '0;
            head_reg        <= '0;
            reload_head_reg <= '0;
            fill_addr_reg   <= '0;
            kaddr_reg       <= '0;
            fill_idx_reg    <= '0;
            idx_reg         <= '0;
            fl_idx_reg      <= '0;
            lo_reg          <= LO_EMPTY;
            hi_reg          <= '0;
            cnt_reg         <= '0;
            op_wr_reg       <= 1'b0;
            to_done_reg     <= 1'b0;
            fl_valid_reg    <= 1'b0;
            k_reset_reg     <= 1'b1;
            done_reg        <= 1'b0;
            kwdata_reg      <= '0;
        end else begin
            case (state_reg)
                S_IDLE, S_DONE: begin
                    if (start) begin
                        base_reg      <= read_base;
                        end_reg       <= read_base + num_words * WB64;
                        head_reg      <= read_base;
                        fill_addr_reg <= read_base;
                        fill_idx_reg  <= '0;
                        done_reg      <= 1'b0;
                        k_reset_reg   <= 1'b1;
                        state_reg     <= S_FILL;
                    end
                end
                S_FILL: begin
                    if (!fill_req || (fill_beat && fill_last)) begin
                        lo_reg      <= LO_EMPTY;
                        hi_reg      <= '0;
                        k_reset_reg <= 1'b0;
                        state_reg   <= S_RUN;
                    end else if (fill_beat) begin
                        fill_addr_reg <= fill_addr_reg + WB64;
                        fill_idx_reg  <= fill_idx_reg + ADDR_WID'(1);
                    end
                end
                S_RUN: begin
                    if (req_any) begin
                        op_wr_reg  <= req_wr;
                        kaddr_reg  <= req_addr;
                        kwdata_reg <= bus.k_wr_data;
                        if (in_win) begin
                            idx_reg   <= req_idx;
                            cnt_reg   <= LAT_CNT;
                            state_reg <= S_SPM_WAIT;
                        end else if (reload_hit) begin
                            // The request stays pending and is re-evaluated once the new window is in.
                            reload_head_reg <= new_head;
                            to_done_reg     <= 1'b0;
                            fl_idx_reg      <= lo_reg[ADDR_WID-1:0];
                            fl_valid_reg    <= 1'b0;
                            state_reg       <= S_FLUSH;
                        end else begin
                            state_reg <= req_wr ? S_HOST_WR : S_HOST_RD;
                        end
                    end else if (k_done) begin
                        to_done_reg  <= 1'b1;
                        fl_idx_reg   <= lo_reg[ADDR_WID-1:0];
                        fl_valid_reg <= 1'b0;
                        state_reg    <= S_FLUSH;
                    end
                end
                S_SPM_WAIT: begin
                    if (cnt_reg == '0) begin
                        state_reg <= S_RUN;
                        if (op_wr_reg) begin
                            if ({1'b0, idx_reg} < lo_reg) lo_reg <= {1'b0, idx_reg};
                            if ({1'b0, idx_reg} > hi_reg) hi_reg <= {1'b0, idx_reg};
                        end
                    end else begin
                        cnt_reg <= cnt_reg - CNT_W'(1);
                    end
                end
                S_HOST_RD: begin
                    if (bus.hrd_ready) state_reg <= S_RUN;
                end
                S_HOST_WR: begin
                    if (bus.hwr_ready) state_reg <= S_RUN;
                end
                S_FLUSH: begin
                    // fl_valid_reg low marks the cycle spent fetching the next dirty word.
                    if (dirty_empty || flush_last) begin
                        lo_reg <= LO_EMPTY;
                        hi_reg <= '0;
                        fl_valid_reg <= 1'b0;
                        if (to_done_reg) begin
                            done_reg    <= 1'b1;
                            k_reset_reg <= 1'b1;
                            state_reg   <= S_DONE;
                        end else begin
                            head_reg      <= reload_head_reg;
                            fill_addr_reg <= reload_head_reg;
                            fill_idx_reg  <= '0;
                            state_reg     <= S_FILL;
                        end
                    end else if (!fl_valid_reg) begin
                        fl_valid_reg <= 1'b1;
                    end else if (bus.hwr_ready) begin
                        fl_idx_reg   <= fl_idx_reg + ADDR_WID'(1);
                        fl_valid_reg <= 1'b0;
                    end
                end
                default: state_reg <= S_IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_spm_window_stream.sv
// Directed bench for spm_window_stream: 32-bit words, 16-word window, latency 5, reload on.
`timescale 1ns/1ps
module tb_spm_window_stream;
    localparam int DW = 32;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        start = 1'b0;
    logic        k_done = 1'b0;
    logic [63:0] read_base = '0;
    logic [63:0] num_words = '0;
    logic        k_reset, done;

    int n_cmp = 0;
    int n_err = 0;
    int cyc = 0;
    int rd_beats = 0;
    int wr_beats = 0;
    int last_rd_cyc = 0;
    logic [63:0] rd_addr_log [256];
    logic [63:0] wr_addr_log [256];
    logic [31:0] wr_data_log [256];

    always #5 clk = ~clk;

    spm_window_stream_if #(.DATA_WID(DW)) bus ();

    spm_window_stream #(
        .DATA_WID(DW), .ADDR_WID(4), .SPM_LAT(5), .RELOAD_EN(1)
    ) dut (
        .clk(clk), .reset(reset), .start(start), .read_base(read_base),
        .num_words(num_words), .k_reset(k_reset), .k_done(k_done), .done(done), .bus(bus)
    );

    function automatic logic [31:0] hword(input logic [63:0] a);
        return 32'h5A00_0000 | {8'h00, a[23:0]};
    endfunction

    // Host model: always ready, read data derived from the address.
    assign bus.hrd_ready = bus.hrd_en;
    assign bus.hrd_data  = hword(bus.hrd_addr);
    assign bus.hwr_ready = bus.hwr_en;

    always @(posedge clk) begin
        cyc <= cyc + 1;
        if (bus.hrd_en && bus.hrd_ready) begin
            rd_addr_log[rd_beats[7:0]] <= bus.hrd_addr;
            rd_beats    <= rd_beats + 1;
            last_rd_cyc <= cyc;
        end
        if (bus.hwr_en && bus.hwr_ready) begin
            wr_addr_log[wr_beats[7:0]] <= bus.hwr_addr;
            wr_data_log[wr_beats[7:0]] <= bus.hwr_data;
            wr_beats <= wr_beats + 1;
        end
    end

    task automatic do_start(input logic [63:0] b, input logic [63:0] n);
        @(posedge clk); #1;
        read_base = b; num_words = n; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
    endtask

    task automatic pulse_k_done();
        @(posedge clk); #1; k_done = 1'b1;
        @(posedge clk); #1; k_done = 1'b0;
    endtask

    // what: 0 k_reset low, 1 done high, 2 rd_beats >= target, 3 wr_beats >= target
    task automatic wait_for(input int what, input int target, output logic ok);
        ok = 1'b0;
        for (int i = 0; i < 500; i++) begin
            @(negedge clk);
            if ((what == 0 && k_reset === 1'b0) || (what == 1 && done === 1'b1) ||
                (what == 2 && rd_beats >= target) || (what == 3 && wr_beats >= target)) begin
                ok = 1'b1;
                break;
            end
        end
    endtask

    task automatic k_access(input logic wr, input logic [63:0] addr, input logic [31:0] wdata,
                            output logic [31:0] rdata, output int lat, output int rd_snap,
                            output logic aligned, output logic ok);
        int c0;
        @(posedge clk); #1;
        c0 = cyc;
        ok = 1'b0; lat = 0; rd_snap = 0; aligned = 1'b0; rdata = '0;
        if (wr) begin
            bus.k_wr_addr = addr; bus.k_wr_data = wdata; bus.k_wr_en = 1'b1;
        end else begin
            bus.k_rd_addr = addr; bus.k_rd_en = 1'b1;
        end
        for (int i = 0; i < 400; i++) begin
            @(negedge clk);
            if (wr ? (bus.k_wr_ready === 1'b1) : (bus.k_rd_ready === 1'b1)) begin
                ok = 1'b1; lat = cyc - c0; rdata = bus.k_rd_data; rd_snap = rd_beats;
                aligned = wr ? (bus.hwr_en && bus.hwr_ready) : (bus.hrd_en && bus.hrd_ready);
                break;
            end
        end
        @(posedge clk); #1;
        bus.k_rd_en = 1'b0; bus.k_wr_en = 1'b0;
    endtask

    task automatic test_reset();
        repeat (3) @(negedge clk);
        n_cmp++; if (k_reset !== 1'b1) begin n_err++; $display("FAIL reset_k_reset got %0b want 1", k_reset); end
        n_cmp++; if (done !== 1'b0) begin n_err++; $display("FAIL reset_done got %0b want 0", done); end
        n_cmp++; if (bus.hrd_en !== 1'b0) begin n_err++; $display("FAIL reset_hrd_en got %0b want 0", bus.hrd_en); end
        n_cmp++; if (bus.hwr_en !== 1'b0) begin n_err++; $display("FAIL reset_hwr_en got %0b want 0", bus.hwr_en); end
        n_cmp++; if (bus.k_rd_ready !== 1'b0 || bus.k_wr_ready !== 1'b0) begin
            n_err++; $display("FAIL reset_k_ready got %0b%0b want 00", bus.k_rd_ready, bus.k_wr_ready); end
        @(posedge clk); #1; reset = 1'b1;
    endtask

    task automatic test_fill();
        int r0, w0; logic ok;
        r0 = rd_beats;
        do_start(64'h1000, 64'd10);
        wait_for(0, 0, ok);
        n_cmp++; if (ok !== 1'b1) begin n_err++; $display("FAIL fill_timeout got %0b want 1", ok); end
        n_cmp++; if (rd_beats - r0 != 10) begin n_err++; $display("FAIL fill_beats got %0d want 10", rd_beats - r0); end
        n_cmp++; if (rd_addr_log[8'(r0)] !== 64'h1000) begin n_err++; $display("FAIL fill_first_addr got %h want 1000", rd_addr_log[8'(r0)]); end
        n_cmp++; if (rd_addr_log[8'(r0 + 9)] !== 64'h1024) begin n_err++; $display("FAIL fill_last_addr got %h want 1024", rd_addr_log[8'(r0 + 9)]); end
        n_cmp++; if (cyc != last_rd_cyc + 1) begin n_err++; $display("FAIL fill_k_reset_fall got cycle %0d want %0d", cyc, last_rd_cyc + 1); end
        w0 = wr_beats;
        pulse_k_done();
        wait_for(1, 0, ok);
        n_cmp++; if (ok !== 1'b1) begin n_err++; $display("FAIL done_timeout got %0b want 1", ok); end
        n_cmp++; if (wr_beats != w0) begin n_err++; $display("FAIL done_clean_wb got %0d want 0", wr_beats - w0); end
        n_cmp++; if (k_reset !== 1'b1) begin n_err++; $display("FAIL done_k_reset got %0b want 1", k_reset); end
    endtask

    task automatic test_spm_read();
        logic [31:0] d; int lat, rs; logic al, ok;
        do_start(64'h1000, 64'd10);
        wait_for(0, 0, ok);
        n_cmp++; if (ok !== 1'b1) begin n_err++; $display("FAIL rd_fill_timeout got %0b want 1", ok); end
        k_access(1'b0, 64'h1008, '0, d, lat, rs, al, ok);
        n_cmp++; if (ok !== 1'b1) begin n_err++; $display("FAIL rd_timeout got %0b want 1", ok); end
        n_cmp++; if (lat != 6) begin n_err++; $display("FAIL rd_latency got %0d want 6", lat); end
        n_cmp++; if (d !== 32'h5A00_1008) begin n_err++; $display("FAIL rd_data got %h want 5a001008", d); end
        @(negedge clk);
        n_cmp++; if (bus.k_rd_ready !== 1'b0) begin n_err++; $display("FAIL rd_pulse_width got %0b want 0", bus.k_rd_ready); end
    endtask

    task automatic test_flush_dirty();
        logic [31:0] d, exp_d; int lat, rs, w0; logic al, ok;
        k_access(1'b1, 64'h100C, 32'hDEAD_0003, d, lat, rs, al, ok);
        n_cmp++; if (ok !== 1'b1 || lat != 6) begin n_err++; $display("FAIL wr_idx3 got ok=%0b lat=%0d want ok=1 lat=6", ok, lat); end
        k_access(1'b1, 64'h101C, 32'hBEEF_0007, d, lat, rs, al, ok);
        n_cmp++; if (ok !== 1'b1) begin n_err++; $display("FAIL wr_idx7 got ok=%0b want 1", ok); end
        k_access(1'b0, 64'h100C, '0, d, lat, rs, al, ok);
        n_cmp++; if (d !== 32'hDEAD_0003) begin n_err++; $display("FAIL wr_readback got %h want dead0003", d); end
        w0 = wr_beats;
        pulse_k_done();
        wait_for(1, 0, ok);
        n_cmp++; if (ok !== 1'b1) begin n_err++; $display("FAIL wb_timeout got %0b want 1", ok); end
        n_cmp++; if (wr_beats - w0 != 5) begin n_err++; $display("FAIL wb_beats got %0d want 5", wr_beats - w0); end
        for (int i = 0; i < 5; i++) begin
            exp_d = (i == 0) ? 32'hDEAD_0003 : (i == 4) ? 32'hBEEF_0007 : hword(64'h100C + 64'(4 * i));
            n_cmp++;
            if (wr_addr_log[8'(w0 + i)] !== 64'h100C + 64'(4 * i) || wr_data_log[8'(w0 + i)] !== exp_d) begin
                n_err++;
                $display("FAIL wb_beat%0d got %h/%h want %h/%h", i, wr_addr_log[8'(w0 + i)],
                         wr_data_log[8'(w0 + i)], 64'h100C + 64'(4 * i), exp_d);
            end
        end
    endtask

    task automatic test_reload();
        logic [31:0] d; int lat, rs, r0, w0; logic al, ok;
        r0 = rd_beats;
        do_start(64'h2000, 64'd40);
        wait_for(0, 0, ok);
        n_cmp++; if (ok !== 1'b1 || rd_beats - r0 != 16) begin n_err++; $display("FAIL rl_first_fill got %0d want 16", rd_beats - r0); end
        k_access(1'b1, 64'h2008, 32'hCAFE_0002, d, lat, rs, al, ok);
        r0 = rd_beats; w0 = wr_beats;
        k_access(1'b0, 64'h2050, '0, d, lat, rs, al, ok);
        n_cmp++; if (ok !== 1'b1 || d !== 32'h5A00_2050) begin n_err++; $display("FAIL rl_word20 got %h want 5a002050", d); end
        n_cmp++; if (rs - r0 != 16) begin n_err++; $display("FAIL rl_fill_before_ready got %0d want 16", rs - r0); end
        n_cmp++; if (wr_beats - w0 != 1) begin n_err++; $display("FAIL rl_flush_beats got %0d want 1", wr_beats - w0); end
        n_cmp++; if (wr_addr_log[8'(w0)] !== 64'h2008 || wr_data_log[8'(w0)] !== 32'hCAFE_0002) begin
            n_err++; $display("FAIL rl_flush_word got %h/%h want 2008/cafe0002", wr_addr_log[8'(w0)], wr_data_log[8'(w0)]); end
        n_cmp++; if (rd_addr_log[8'(r0)] !== 64'h2040) begin n_err++; $display("FAIL rl_fill_addr got %h want 2040", rd_addr_log[8'(r0)]); end
        r0 = rd_beats; w0 = wr_beats;
        k_access(1'b0, 64'h208C, '0, d, lat, rs, al, ok);
        n_cmp++; if (ok !== 1'b1 || d !== 32'h5A00_208C) begin n_err++; $display("FAIL rl_word35 got %h want 5a00208c", d); end
        n_cmp++; if (rd_beats - r0 != 8 || rd_addr_log[8'(r0)] !== 64'h2080) begin
            n_err++; $display("FAIL rl_short_window got %0d beats from %h want 8 from 2080", rd_beats - r0, rd_addr_log[8'(r0)]); end
        n_cmp++; if (wr_beats != w0) begin n_err++; $display("FAIL rl_clean_flush got %0d want 0", wr_beats - w0); end
    endtask

    task automatic test_passthrough();
        logic [31:0] d; int lat, rs, r0, w0; logic al, ok;
        r0 = rd_beats;
        k_access(1'b0, 64'h0500, '0, d, lat, rs, al, ok);
        n_cmp++; if (ok !== 1'b1 || d !== 32'h5A00_0500) begin n_err++; $display("FAIL pt_rd_data got %h want 5a000500", d); end
        n_cmp++; if (al !== 1'b1 || rd_addr_log[8'(r0)] !== 64'h0500) begin
            n_err++; $display("FAIL pt_rd_align got %0b addr %h want 1 addr 500", al, rd_addr_log[8'(r0)]); end
        w0 = wr_beats;
        k_access(1'b1, 64'h20A0, 32'h1234_5678, d, lat, rs, al, ok);
        n_cmp++; if (ok !== 1'b1 || al !== 1'b1) begin n_err++; $display("FAIL pt_wr_align got ok=%0b al=%0b want 1 1", ok, al); end
        n_cmp++; if (wr_beats - w0 != 1 || wr_addr_log[8'(w0)] !== 64'h20A0 || wr_data_log[8'(w0)] !== 32'h1234_5678) begin
            n_err++; $display("FAIL pt_wr_beat got %0d %h/%h want 1 20a0/12345678", wr_beats - w0, wr_addr_log[8'(w0)], wr_data_log[8'(w0)]); end
        k_access(1'b0, 64'h2084, '0, d, lat, rs, al, ok);
        n_cmp++; if (d !== 32'h5A00_2084 || lat != 6) begin n_err++; $display("FAIL pt_window_kept got %h lat %0d want 5a002084 lat 6", d, lat); end
        n_cmp++; if (rd_beats - r0 != 1) begin n_err++; $display("FAIL pt_no_refill got %0d want 1", rd_beats - r0); end
        pulse_k_done();
        wait_for(1, 0, ok);
        n_cmp++; if (ok !== 1'b1) begin n_err++; $display("FAIL pt_done got %0b want 1", ok); end
    endtask

    task automatic test_reset_mid_op();
        logic [31:0] d; int lat, rs, r0, w0; logic al, ok;
        r0 = rd_beats;
        do_start(64'h3000, 64'd10);
        wait_for(2, r0 + 5, ok);
        #1 reset = 1'b0;
        #1;
        n_cmp++; if (bus.hrd_en !== 1'b0 || bus.hrd_addr !== 64'h0 || k_reset !== 1'b1 || done !== 1'b0) begin
            n_err++; $display("FAIL rst_fill_outputs got hrd_en=%0b addr=%h k_reset=%0b done=%0b want 0 0 1 0",
                              bus.hrd_en, bus.hrd_addr, k_reset, done); end
        repeat (4) @(posedge clk);
        #1;
        n_cmp++; if (ok !== 1'b1 || rd_beats - r0 != 5) begin n_err++; $display("FAIL rst_fill_beats got %0d want 5", rd_beats - r0); end
        reset = 1'b1;
        do_start(64'h3000, 64'd10);
        wait_for(0, 0, ok);
        k_access(1'b1, 64'h3000, 32'hAAAA_0000, d, lat, rs, al, ok);
        k_access(1'b1, 64'h3014, 32'hAAAA_0005, d, lat, rs, al, ok);
        w0 = wr_beats;
        pulse_k_done();
        wait_for(3, w0 + 2, ok);
        #1 reset = 1'b0;
        #1;
        n_cmp++; if (bus.hwr_en !== 1'b0 || k_reset !== 1'b1 || done !== 1'b0) begin
            n_err++; $display("FAIL rst_flush_outputs got hwr_en=%0b k_reset=%0b done=%0b want 0 1 0", bus.hwr_en, k_reset, done); end
        repeat (20) @(posedge clk);
        #1;
        n_cmp++; if (ok !== 1'b1 || wr_beats - w0 != 2 || done !== 1'b0) begin
            n_err++; $display("FAIL rst_flush_beats got %0d done=%0b want 2 done=0", wr_beats - w0, done); end
        reset = 1'b1;
    endtask

    initial begin
        bus.k_rd_en = 1'b0; bus.k_rd_addr = '0;
        bus.k_wr_en = 1'b0; bus.k_wr_addr = '0; bus.k_wr_data = '0;
        test_reset();
        test_fill();
        test_spm_read();
        test_flush_dirty();
        test_reload();
        test_passthrough();
        test_reset_mid_op();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog got no finish want finish before 2ms");
        $fatal(1, "watchdog expired");
    end
endmodule
